// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: reads NUM_OF_WORDS words from word memory and streams
// the padded message (marker, zero fill, 64-bit length) over valid/ready.
module sha256_msg_padder #(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] message_addr,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    input  logic [31:0] mem_read_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        out_last_in_block,
    output logic        out_last,
    output logic [7:0]  out_block_idx,
    output logic        busy,
    output logic        done
);

    localparam int          NUM_BLOCKS = (NUM_OF_WORDS + 3 + 15) / 16;
    localparam logic [15:0] MSG_LEN    = 16'(NUM_OF_WORDS);
    localparam logic [15:0] LAST_IDX   = 16'(16 * NUM_BLOCKS - 1);
    localparam logic [31:0] LEN_BITS   = 32'(NUM_OF_WORDS * 32);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_CAP,
        OUT,
        PAD,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] mem_addr_d;
    logic        out_valid_d;
    logic [31:0] out_word_d;
    logic        out_last_in_block_d;
    logic        out_last_d;
    logic [7:0]  out_block_idx_d;
    logic        busy_d;
    logic        done_d;
    logic [15:0] idx_nxt;

    assign mem_clk = clk;
    assign mem_we  = 1'b0;
    assign idx_nxt = idx_q + 16'd1;

    // Padding content depends only on the word index once the message is exhausted.
    function automatic logic [31:0] pad_word(input logic [15:0] j);
        logic [31:0] w;
        w = '0;
        if (j == MSG_LEN)
            w = 32'h8000_0000;
        else if (j == LAST_IDX)
            w = LEN_BITS;
        return w;
    endfunction

    always_comb begin
        state_d             = state_q;
        idx_d               = idx_q;
        mem_addr_d          = mem_addr;
        out_valid_d         = out_valid;
        out_word_d          = out_word;
        out_last_in_block_d = out_last_in_block;
        out_last_d          = out_last;
        out_block_idx_d     = out_block_idx;
        busy_d              = busy;
        done_d              = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RD_ADDR;
                    idx_d      = '0;
                    mem_addr_d = message_addr;
                    busy_d     = 1'b1;
                end
            end
            RD_ADDR: state_d = RD_CAP;
            RD_CAP: begin
                out_word_d          = mem_read_data;
                out_valid_d         = 1'b1;
                out_last_in_block_d = (idx_q[3:0] == 4'hF);
                out_last_d          = (idx_q == LAST_IDX);
                out_block_idx_d     = idx_q[11:4];
                state_d             = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    idx_d      = idx_nxt;
                    mem_addr_d = mem_addr + 16'd1;
                    if (idx_nxt < MSG_LEN) begin
                        out_valid_d = 1'b0;
                        state_d     = RD_ADDR;
                    end else begin
                        // Marker word is loaded here so PAD starts with valid already high.
                        out_word_d          = pad_word(idx_nxt);
                        out_last_in_block_d = (idx_nxt[3:0] == 4'hF);
                        out_last_d          = (idx_nxt == LAST_IDX);
                        out_block_idx_d     = idx_nxt[11:4];
                        state_d             = PAD;
                    end
                end
            end
            PAD: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        state_d     = DONE;
                    end else begin
                        idx_d               = idx_nxt;
                        out_word_d          = pad_word(idx_nxt);
                        out_last_in_block_d = (idx_nxt[3:0] == 4'hF);
                        out_last_d          = (idx_nxt == LAST_IDX);
                        out_block_idx_d     = idx_nxt[11:4];
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            idx_q             <= '0;
            mem_addr          <= '0;
            out_valid         <= 1'b0;
            out_word          <= '0;
            out_last_in_block <= 1'b0;
            out_last          <= 1'b0;
            out_block_idx     <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            state_q           <= state_d;
            idx_q             <= idx_d;
            mem_addr          <= mem_addr_d;
            out_valid         <= out_valid_d;
            out_word          <= out_word_d;
            out_last_in_block <= out_last_in_block_d;
            out_last          <= out_last_d;
            out_block_idx     <= out_block_idx_d;
            busy              <= busy_d;
            done              <= done_d;
        end
    end

endmodule
